// File: rtl/tt_adder_acc.sv
// Add/subtract/accumulate unit. Results go into an output FIFO with valid/ready handshakes.
// Defining TT_ADDER_ACC_SAT_EN makes ADD/ACC saturate to all-ones and SUB saturate to zero.
module tt_adder_acc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               op_a,
    input  logic [WIDTH-1:0]               op_b,
    input  logic [1:0]                     mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               result,
    output logic                           carry,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

`ifdef TT_ADDER_ACC_SAT_EN
    function automatic logic [WIDTH-1:0] clamp_add(input logic [WIDTH:0] s);
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] clamp_sub(input logic [WIDTH:0] d);
        return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] clamp_add(input logic [WIDTH:0] s);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] clamp_sub(input logic [WIDTH:0] d);
        return d[WIDTH-1:0];
    endfunction
`endif

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mem_res [DEPTH];
    logic [DEPTH-1:0] mem_cy;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    logic [WIDTH:0]   sum_p0;
    logic [WIDTH:0]   diff_p0;
    logic [WIDTH:0]   acc_sum_p0;
    logic [WIDTH-1:0] res_p0;
    logic             cy_p0;
    logic             acc_ld_p0;
    logic [WIDTH-1:0] acc_nxt_p0;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Stage p0: combinational operation on the presented operands
    always_comb begin
        sum_p0     = {1'b0, op_a} + {1'b0, op_b};
        diff_p0    = {1'b0, op_a} - {1'b0, op_b};
        acc_sum_p0 = {1'b0, acc} + {1'b0, op_a};
        res_p0     = '0;
        cy_p0      = 1'b0;
        acc_ld_p0  = 1'b0;
        acc_nxt_p0 = acc;
        case (mode)
            MODE_ADD: begin
                res_p0 = clamp_add(sum_p0);
                cy_p0  = sum_p0[WIDTH];
            end
            MODE_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                res_p0 = clamp_sub(diff_p0);
                cy_p0  = diff_p0[WIDTH];
            end
            MODE_ACC: begin
                res_p0     = clamp_add(acc_sum_p0);
                cy_p0      = acc_sum_p0[WIDTH];
                acc_ld_p0  = 1'b1;
                acc_nxt_p0 = res_p0;
            end
            MODE_CLR: begin
                acc_ld_p0  = 1'b1;
                acc_nxt_p0 = '0;
            end
            default: begin
                res_p0 = '0;
            end
        endcase
    end

    // Stage p1: FIFO storage, pointers, occupancy and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            acc    <= '0;
            mem_cy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_res[wr_ptr] <= res_p0;
                mem_cy[wr_ptr]  <= cy_p0;
                wr_ptr          <= wr_ptr + PW'(1);
                if (acc_ld_p0) begin
                    acc <= acc_nxt_p0;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign result = out_valid ? mem_res[rd_ptr] : '0;
    assign carry  = out_valid ? mem_cy[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_tt_adder_acc.sv
// Scoreboard bench for tt_adder_acc: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the add/sub/accumulate rules.
module tb_tt_adder_acc;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int MAXV  = 2 ** W;
`ifdef TT_ADDER_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic [2:0]   count;

    tt_adder_acc #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] got_log[$];
    int           macc;
    bit           armed = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] acc_exp [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation rules.
    task automatic model(input logic [1:0] m, input int a, input int b, output exp_t e);
        int s;
        case (m)
            2'b00: begin
                s   = a + b;
                e.c = (s >= MAXV);
                e.r = W'(s % MAXV);
                if (SAT && e.c) e.r = W'(MAXV - 1);
            end
            2'b01: begin
                e.c = (a < b);
                e.r = W'((a - b + MAXV) % MAXV);
                if (SAT && e.c) e.r = '0;
            end
            2'b10: begin
                s   = macc + a;
                e.c = (s >= MAXV);
                e.r = W'(s % MAXV);
                if (SAT && e.c) e.r = W'(MAXV - 1);
                macc = int'(e.r);
            end
            default: begin
                e.r  = '0;
                e.c  = 1'b0;
                macc = 0;
            end
        endcase
    endtask

    // Monitor: state checks, pops compared against the scoreboard, pushes modelled.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("count", 32'(count), 32'(sbq.size()));
            chk("in_ready", 32'(in_ready), 32'(sbq.size() < D));
            chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            if (!out_valid) begin
                chk("idle_result", 32'(result), 32'h0);
                chk("idle_carry", 32'(carry), 32'h0);
            end
        end
        if (rst) begin
            sbq.delete();
            macc  = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pop", 32'(out_valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", 32'(result), 32'(e.r));
                    chk("carry", 32'(carry), 32'(e.c));
                end
                got_log.push_back(result);
            end
            if (in_valid && in_ready) begin
                model(mode, int'(op_a), int'(op_b), e);
                sbq.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the push edge.
    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        int waitc = 0;
        in_valid = 1'b1;
        mode     = m;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (count != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(count), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        acc_exp   = '{8'h10, 8'h30, 8'h60, 8'h00, 8'h05};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        mode      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_result", 32'(result), 32'h0);

        send(2'b00, 8'h70, 8'h20);
        chk("add_basic_valid", 32'(out_valid), 32'h1);
        chk("add_basic_result", 32'(result), 32'h90);
        chk("add_basic_carry", 32'(carry), 32'h0);

        send(2'b00, 8'hF0, 8'h20);
        chk("add_ovf_result", 32'(result), SAT ? 32'hFF : 32'h10);
        chk("add_ovf_carry", 32'(carry), 32'h1);

        send(2'b01, 8'h05, 8'h07);
        chk("sub_borrow_result", 32'(result), SAT ? 32'h00 : 32'hFE);
        chk("sub_borrow_carry", 32'(carry), 32'h1);
        drain();

        got_log.delete();
        send(2'b10, 8'h10, 8'hAA);
        send(2'b10, 8'h20, 8'h55);
        send(2'b10, 8'h30, 8'h00);
        send(2'b11, 8'h77, 8'h77);
        send(2'b10, 8'h05, 8'hFF);
        drain();
        chk("acc_seq_len", 32'(got_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("acc_seq", 32'(got_log[i]), 32'(acc_exp[i]));
        end

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'b00, W'($urandom), W'($urandom));
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        fork
            send(2'b00, W'($urandom), W'($urandom));
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("full_hold_count", 32'(count), 32'd4);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("first_pop_in_ready", 32'(in_ready), 32'h1);
                chk("first_pop_count", 32'(count), 32'd3);
            end
        join
        drain();

        send(2'b11, 8'h00, 8'h00);
        send(2'b10, 8'h40, 8'h00);
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(2'b00, W'($urandom), W'($urandom));
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_out_valid", 32'(out_valid), 32'h0);
        chk("post_rst_count", 32'(count), 32'h0);
        chk("post_rst_result", 32'(result), 32'h0);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        send(2'b10, 8'h01, 8'h00);
        chk("post_rst_acc", 32'(result), 32'h01);
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 39) == 0) begin
                        in_valid = 1'b1;
                        mode     = 2'($urandom);
                        op_a     = W'($urandom);
                        op_b     = W'($urandom);
                        rst      = 1'b1;
                        @(posedge clk);
                        #1;
                        rst      = 1'b0;
                        in_valid = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        send(2'($urandom), W'($urandom), W'($urandom));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_adder_acc.md
TT_ADDER_ACC -- requirements
Module: tt_adder_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, result and accumulator width in bits, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1: the block can accept an operation.
REQ-007 SHALL have port op_a, input, WIDTH: first operand.
REQ-008 SHALL have port op_b, input, WIDTH: second operand, ignored in ACC and CLR modes.
REQ-009 SHALL have port mode, input, 2: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-010 SHALL have port out_valid, output, 1: the FIFO head is valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the head.
REQ-012 SHALL have port result, output, WIDTH: FIFO head result.
REQ-013 SHALL have port carry, output, 1: FIFO head carry/borrow flag.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1): FIFO occupancy.

Function
REQ-015 SHALL accept an operation (push) on a cycle where in_valid=1 and in_ready=1.
REQ-016 SHALL pop the FIFO head on a cycle where out_valid=1 and out_ready=1.
REQ-017 SHALL drive in_ready=1 exactly when count<DEPTH, with no combinational path from out_ready.
REQ-018 SHALL compute the result in the push cycle and present it on result/carry with out_valid=1 on the next cycle when the FIFO was empty (latency 1).
REQ-019 SHALL compute ADD as op_a+op_b modulo 2^WIDTH, with carry = bit WIDTH of the full sum.
REQ-020 SHALL compute SUB as op_a-op_b modulo 2^WIDTH, with carry=1 exactly when op_a<op_b (borrow).
REQ-021 SHALL in ACC mode load acc with acc+op_a modulo 2^WIDTH, push the new acc value as result, and set carry from the addition.
REQ-022 SHALL in CLR mode load acc with 0 and push result 0, carry 0.
REQ-023 SHALL leave acc unchanged in ADD and SUB modes and on cycles with no push.
REQ-024 SHALL on simultaneous push and pop leave count unchanged and preserve strict FIFO order.
REQ-025 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-026 SHALL drive result=0 and carry=0 whenever out_valid=0.
REQ-027 SHALL hold result, carry and out_valid stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, clear count, pointers, acc and FIFO storage, giving out_valid=0, result=0, carry=0, count=0 and in_ready=1 on the following cycle.
REQ-029 SHALL let rst override a push or pop in the same cycle, discarding FIFO contents and an in-flight operation.

Configuration
REQ-030 SHALL, with macro TT_ADDER_ACC_SAT_EN defined, saturate: ADD/ACC results with carry=1 become all-ones (the clamped value is also stored in acc), SUB results with borrow become 0; carry still reports overflow/borrow.
REQ-031 SHALL, with TT_ADDER_ACC_SAT_EN undefined, produce wrap-around results only, with no saturation logic present.

Verification (WIDTH=8, DEPTH=4)
REQ-032 SHALL cover: ADD op_a=0x70, op_b=0x20, out_ready=1 -> next cycle out_valid=1, result=0x90, carry=0.
REQ-033 SHALL cover: ADD 0xF0+0x20 -> result 0x10, carry 1; with SAT_EN defined -> result 0xFF, carry 1.
REQ-034 SHALL cover: SUB 0x05-0x07 -> result 0xFE, carry 1; with SAT_EN defined -> result 0x00, carry 1.
REQ-035 SHALL cover: ACC 0x10, 0x20, 0x30, then CLR, then ACC 0x05 -> results 0x10, 0x30, 0x60, 0x00, 0x05 in order.
REQ-036 SHALL cover: out_ready=0 with 5 back-to-back ADDs -> 4 accepted, count=4, in_ready=0 after the 4th; then out_ready=1 -> 4 results drain in push order and in_ready returns to 1 after the first pop.
REQ-037 SHALL cover: count=3, acc=0x40, rst pulsed for 1 cycle -> next cycle out_valid=0, count=0, result=0, in_ready=1; a following ACC 0x01 yields 0x01.
